carry_lookahead_serial_adder: RTL and testbench



---
 rtl/cla_add_pkg.sv | 17 +
 rtl/cla_4_bit_slice.sv | 36 +++
 rtl/carry_lookahead_serial_adder.sv | 114 +++++++++++
 tb/tb_carry_lookahead_serial_adder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_add_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 4;

    // Width of the nibble index; a single-nibble adder still needs one bit.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_4_bit_slice.sv
// Combinational 4-bit carry-lookahead adder slice; also exports the carry into bit 3.
module cla_4_bit_slice
    import cla_add_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co,
    output logic               c3
);

    logic [SLICE_W-1:0] p_s;
    logic [SLICE_W-1:0] g_s;
    logic               c1_s;
    logic               c2_s;
    logic               c3_s;
    logic               c4_s;

    assign p_s = x ^ y;
    assign g_s = x & y;

    // Every carry is a flat sum of generate/propagate products, never a ripple.
    assign c1_s = g_s[0] | (p_s[0] & ci);
    assign c2_s = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & ci);
    assign c3_s = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & ci);
    assign c4_s = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & ci);

    assign s  = p_s ^ {c3_s, c2_s, c1_s, ci};
    assign co = c4_s;
    assign c3 = c3_s;

endmodule

// File: rtl/carry_lookahead_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one CLA nibble per clock, LSB nibble first.
// Define CLA_ADD_OVF_EN to add the signed-overflow output ovf.
module carry_lookahead_serial_adder
    import cla_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef CLA_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NIB   = WIDTH / SLICE_W;
    localparam int IDX_W = idx_width(NIB);

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;

    logic [SLICE_W-1:0] x_s;
    logic [SLICE_W-1:0] y_s;
    logic [SLICE_W-1:0] s_s;
    logic               co_s;
    logic               c3_s;
    logic               last_s;

    assign x_s    = a_r[{idx_r, 2'b00} +: SLICE_W];
    assign y_s    = b_r[{idx_r, 2'b00} +: SLICE_W];
    assign last_s = (idx_r == IDX_W'(NIB - 1));

    cla_4_bit_slice u_slice (
        .x  (x_s),
        .y  (y_s),
        .ci (carry_r),
        .s  (s_s),
        .co (co_s),
        .c3 (c3_s)
    );

`ifndef CLA_ADD_OVF_EN
    logic c3_unused_s;
    assign c3_unused_s = c3_s;
`endif

    // Handshake flags decode directly from the state register.
    assign in_ready  = (state_r == IDLE) && rst_n;
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);

    // Sequencer: accept operands, step one nibble per cycle, hold the result until taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= {IDX_W{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            sum     <= {WIDTH{1'b0}};
            cout    <= 1'b0;
`ifdef CLA_ADD_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    sum[{idx_r, 2'b00} +: SLICE_W] <= s_s;
                    carry_r <= co_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        cout    <= co_s;
`ifdef CLA_ADD_OVF_EN
                        // Signed overflow: carry into the sign bit differs from carry out of it.
                        ovf     <= c3_s ^ co_s;
`endif
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carry_lookahead_serial_adder.sv
// Directed self-checking bench for carry_lookahead_serial_adder (WIDTH=16).
// Honours CLA_ADD_OVF_EN to also check the ovf output.
module tb_carry_lookahead_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_ADD_OVF_EN
    logic             ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    carry_lookahead_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef CLA_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation from IDLE; the result is held for 'hold' cycles before being taken.
    task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic [15:0] es, input logic ec,
                         input logic eo, input int hold);
        int lat;
        a         = ta;
        b         = tb;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        chk($sformatf("%s_in_ready", tag), 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk($sformatf("%s_latency", tag), 32'(lat), 32'(NIB));
        chk($sformatf("%s_sum", tag), 32'(sum), 32'(es));
        chk($sformatf("%s_cout", tag), 32'(cout), 32'(ec));
`ifdef CLA_ADD_OVF_EN
        chk($sformatf("%s_ovf", tag), 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: ovf expectation undefined for %s", tag);
`endif
        repeat (hold) tick();
        out_ready = 1'b1;
        tick();
        chk($sformatf("%s_released", tag), 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] rs;
        logic        ro;
        int          cnt;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        cin       = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
`ifdef CLA_ADD_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready_high", 32'(in_ready), 32'd1);

        do_op("basic",   16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        do_op("ripple",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
        do_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        do_op("mixed",   16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0, 0);
        do_op("negovf",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 2);
        do_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0);

        // Backpressure: result must hold while a competing request is ignored.
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (NIB) tick();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_sum", 32'(sum), 32'h1010);
        a = 16'h1111; b = 16'h1111; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold%0d", i),
                32'({out_valid, in_ready, busy, cout, sum}), 32'({4'b1010, 16'h1010}));
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release", 32'({out_valid, in_ready}), 32'b01);
        tick();
        in_valid = 1'b0;
        chk("bp_next_busy", 32'(busy), 32'd1);
        repeat (NIB) tick();
        chk("bp_next_sum", 32'({out_valid, cout, sum}), 32'({2'b10, 16'h2222}));
        tick();

        // Back-to-back issue with in_valid and out_ready held high.
        a = 16'h0003; b = 16'h0004; cin = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("b2b_interval", 32'(cnt + 1), 32'd6);
        a = 16'h0010; b = 16'h0020; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (NIB) tick();
        chk("b2b_second", 32'({out_valid, sum}), 32'({1'b1, 16'h0030}));
        tick();
        chk("b2b_single_valid", 32'(out_valid), 32'd0);

        // Reset in the second RUN cycle discards the operation.
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("midrst_state", 32'({busy, out_valid, cout, sum}), 32'd0);
        rst_n = 1'b1;
        #1;
        do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        // Short random run against plain integer addition.
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            ro = (ra[15] == rb[15]) && (rs[15] != ra[15]);
            do_op($sformatf("rnd%0d", i), ra, rb, rc, rs[15:0], rs[16], ro,
                  int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
